jtag_dr_queue: RTL



---
 rtl/jtag_dr_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/jtag_dr_queue.sv
// rtl/jtag_dr_queue.sv - JTAG {address, data} register with length check and update queue
// Captured/shifted chain is pushed into a small FIFO on each Update-DR edge.
module jtag_dr_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                        JTCK,
  input  logic                        JRST,
  input  logic                        JTDI,
  output logic                        JTDO,
  input  logic                        JSHIFT,
  input  logic                        JCE,
  input  logic                        JUPDATE,
  input  logic                        JTAGREG_ENABLE,
  input  logic [DATA_WIDTH-1:0]       REG_D,
  input  logic [ADDR_WIDTH-1:0]       REG_ADDR_D,
  output logic [DATA_WIDTH-1:0]       REG_Q,
  output logic [ADDR_WIDTH-1:0]       REG_ADDR_Q,
  output logic                        REG_VALID,
  input  logic                        REG_READY,
  output logic                        REG_UPDATE,
  output logic [$clog2(DEPTH):0]      LEVEL,
  output logic                        LEN_ERR,
  output logic                        OVF_ERR,
  input  logic                        ERR_CLR
);

  localparam int L  = DATA_WIDTH + ADDR_WIDTH;
  localparam int CW = $clog2(L + 2);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [CW-1:0] CNT_LEN = CW'(L);
  localparam logic [CW-1:0] CNT_SAT = CW'(L + 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [L-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          upd_q;
  logic [L-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [LW-1:0] level_r;
  logic [L-1:0]  head;

  logic en, upd, len_ok, full, pop, push, len_bad, ovf;

  assign en      = JTAGREG_ENABLE & JCE;
  assign upd     = JUPDATE & ~upd_q & JTAGREG_ENABLE;
  assign len_ok  = (cnt == CNT_LEN);
  assign full    = (level_r == LVL_MAX);
  assign pop     = REG_VALID & REG_READY;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push    = upd & len_ok & (~full | pop) & ~JRST;
  assign len_bad = upd & ~len_ok;
  assign ovf     = upd & len_ok & full & ~pop;

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      sr         <= '0;
      cnt        <= '0;
      upd_q      <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      level_r    <= '0;
      REG_UPDATE <= 1'b0;
      LEN_ERR    <= 1'b0;
      OVF_ERR    <= 1'b0;
    end else begin
      upd_q <= JUPDATE;
      if (en) begin
        if (JSHIFT) begin
          sr <= {sr[L-2:0], JTDI};
          if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
        end else begin
          sr  <= {REG_ADDR_D, REG_D};
          cnt <= '0;
        end
      end
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      REG_UPDATE <= push;
      // A new error wins over a simultaneous clear.
      LEN_ERR <= (LEN_ERR & ~ERR_CLR) | len_bad;
      OVF_ERR <= (OVF_ERR & ~ERR_CLR) | ovf;
    end
  end

  always_ff @(posedge JTCK) begin
    if (push) mem[wp] <= sr;
  end

  assign head       = mem[rp];
  assign JTDO       = sr[L-1];
  assign LEVEL      = level_r;
  assign REG_VALID  = (level_r != '0);
  assign REG_Q      = REG_VALID ? head[DATA_WIDTH-1:0] : '0;
  assign REG_ADDR_Q = REG_VALID ? head[L-1:DATA_WIDTH] : '0;

endmodule
